// File: rtl/cache_controller.sv
// Sequencing controller for a direct-mapped, 32-entry, one-word-per-block cache array
// sitting between the core data port and a multi-cycle main memory.
module cache_controller #(
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned DATA_W  = 32,
    localparam int unsigned ADDR_W  = 10,
    localparam int unsigned IDX_W   = 5,
    localparam int unsigned TAG_W   = 3,
    localparam int unsigned OFF_W   = 2,
    localparam int unsigned WADDR_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_done,
    output logic               busy,
    input  logic               stat_clr,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt,
    output logic [DATA_W-1:0]  cache_data_in,
    output logic [IDX_W-1:0]   cache_block_num,
    output logic [OFF_W-1:0]   cache_byte_offset,
    output logic [TAG_W-1:0]   cache_in_tag,
    output logic               cache_in_valid,
    output logic               cache_WE,
    input  logic [DATA_W-1:0]  cache_data_out,
    input  logic [TAG_W-1:0]   cache_out_tag,
    input  logic               cache_out_valid,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMPARE = 3'd1,
        S_MEM_RD  = 3'd2,
        S_FILL    = 3'd3,
        S_MEM_WR  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   fill_q;

    logic                hit_c;
    logic                accept_c;
    logic                done_c;
    logic                rd_hit_c;
    logic                rd_fill_c;
    logic                fill_cap_c;
    logic                hit_inc_c;
    logic                miss_inc_c;
    logic                cache_we_c;
    logic                mem_req_c;
    logic                mem_we_c;
    logic [DATA_W-1:0]   cache_din_c;

    assign hit_c = cache_out_valid && (cache_out_tag == addr_q[ADDR_W-1 -: TAG_W]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state plus the strobes that the array/memory see directly from the state.
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        done_c      = 1'b0;
        rd_hit_c    = 1'b0;
        rd_fill_c   = 1'b0;
        fill_cap_c  = 1'b0;
        hit_inc_c   = 1'b0;
        miss_inc_c  = 1'b0;
        cache_we_c  = 1'b0;
        cache_din_c = wdata_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    accept_c = 1'b1;
                    state_d  = S_COMPARE;
                end
            end
            S_COMPARE: begin
                hit_inc_c  = hit_c;
                miss_inc_c = !hit_c;
                if (we_q) begin
                    cache_we_c = 1'b1;
                    state_d    = S_MEM_WR;
                end else if (hit_c) begin
                    rd_hit_c = 1'b1;
                    done_c   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                if (mem_ack) begin
                    fill_cap_c = 1'b1;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                cache_we_c  = 1'b1;
                cache_din_c = fill_q;
                rd_fill_c   = 1'b1;
                done_c      = 1'b1;
                state_d     = S_IDLE;
            end
            S_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                if (mem_ack) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, fill buffer and core-side response registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            fill_q    <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
        end else begin
            cpu_done <= done_c;
            if (accept_c) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
            if (fill_cap_c) fill_q <= mem_rdata;
            if (rd_hit_c)        cpu_rdata <= cache_data_out;
            else if (rd_fill_c)  cpu_rdata <= fill_q;
        end
    end

    // Saturating statistics; a clear beats a same-cycle increment.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (stat_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc_c  && (hit_cnt  != '1)) hit_cnt  <= hit_cnt  + CNT_W'(1);
            if (miss_inc_c && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign cache_block_num   = addr_q[OFF_W +: IDX_W];
    assign cache_in_tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign cache_byte_offset = addr_q[OFF_W-1:0];
    assign cache_data_in     = cache_din_c;
    assign cache_WE          = cache_we_c;
    assign cache_in_valid    = cache_we_c;
    assign mem_req           = mem_req_c;
    assign mem_we            = mem_we_c;
    assign mem_addr          = addr_q[ADDR_W-1:OFF_W];
    assign mem_wdata         = wdata_q;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural cache array and memory around the DUT,
// a transaction-level reference model, directed table, random traffic and corner sequences.
module tb_cache_controller;
    localparam int unsigned CNT_W = 8;
    localparam int SAT = 255;

    logic        CLK, RST;
    logic        cpu_req, cpu_we, cpu_done, busy, stat_clr;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;
    logic [31:0] cache_data_in, cache_data_out;
    logic [4:0]  cache_block_num;
    logic [1:0]  cache_byte_offset;
    logic [2:0]  cache_in_tag, cache_out_tag;
    logic        cache_in_valid, cache_WE, cache_out_valid;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    cache_controller #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .busy(busy),
        .stat_clr(stat_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
        .cache_data_in(cache_data_in), .cache_block_num(cache_block_num),
        .cache_byte_offset(cache_byte_offset), .cache_in_tag(cache_in_tag),
        .cache_in_valid(cache_in_valid), .cache_WE(cache_WE), .cache_data_out(cache_data_out),
        .cache_out_tag(cache_out_tag), .cache_out_valid(cache_out_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    // Environment: the cache array (combinational read, clocked write).
    logic [31:0] c_data  [32];
    logic [2:0]  c_tag   [32];
    logic        c_valid [32];
    int          wr_cnt = 0;
    logic [4:0]  last_idx;
    logic [2:0]  last_tag;
    logic [31:0] last_data;
    logic        last_valid;

    assign cache_data_out  = c_data[cache_block_num];
    assign cache_out_tag   = c_tag[cache_block_num];
    assign cache_out_valid = c_valid[cache_block_num];

    always @(posedge CLK) begin
        if (cache_WE) begin
            c_data[cache_block_num]  <= cache_data_in;
            c_tag[cache_block_num]   <= cache_in_tag;
            c_valid[cache_block_num] <= cache_in_valid;
            wr_cnt     <= wr_cnt + 1;
            last_idx   <= cache_block_num;
            last_tag   <= cache_in_tag;
            last_data  <= cache_data_in;
            last_valid <= cache_in_valid;
        end
    end

    // Environment: main memory with programmable ack latency, plus interface monitor.
    logic [31:0] mem_store [256];
    int          mem_lat = 1;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    int          mem_bad = 0;
    logic [7:0]  exp_mem_addr;
    logic        exp_mem_we;
    logic [31:0] exp_mem_wd;

    always @(negedge CLK) begin
        if (mem_req) begin
            req_cycles++;
            if (mem_addr !== exp_mem_addr || mem_we !== exp_mem_we ||
                (exp_mem_we && mem_wdata !== exp_mem_wd)) mem_bad++;
        end
        if (mem_ack) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end else if (mem_req) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
                wait_cnt = 0;
                mem_ack  = 1'b1;
                if (mem_we) mem_store[mem_addr] = mem_wdata;
                mem_rdata = mem_store[mem_addr];
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Reference model: cache contents, memory image and counters at transaction level.
    logic        ref_valid [32];
    logic [2:0]  ref_tag   [32];
    logic [31:0] ref_data  [32];
    logic [31:0] ref_mem   [256];
    int          ref_hit = 0;
    int          ref_miss = 0;

    task automatic ref_access(input logic we, input logic [9:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic hit);
        int idx = int'(a[6:2]);
        int w   = int'(a[9:2]);
        hit = ref_valid[idx] && (ref_tag[idx] == a[9:7]);
        if (hit) ref_hit  = (ref_hit  < SAT) ? ref_hit  + 1 : SAT;
        else     ref_miss = (ref_miss < SAT) ? ref_miss + 1 : SAT;
        rd = 32'h0;
        if (we) begin
            ref_valid[idx] = 1'b1; ref_tag[idx] = a[9:7]; ref_data[idx] = wd; ref_mem[w] = wd;
        end else if (hit) begin
            rd = ref_data[idx];
        end else begin
            rd = ref_mem[w];
            ref_valid[idx] = 1'b1; ref_tag[idx] = a[9:7]; ref_data[idx] = rd;
        end
    endtask

    // One core transaction, entered and left on a falling edge.
    task automatic access(input logic we, input logic [9:0] a, input logic [31:0] wd,
                          input int lat, output logic [31:0] got_rd, output int got_cyc);
        mem_lat = lat;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(negedge CLK);
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 10'($urandom); cpu_wdata = $urandom;
        got_cyc = 0;
        got_rd  = 32'h0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (cpu_done) begin
                got_cyc = i;
                got_rd  = cpu_rdata;
                break;
            end
        end
        if (got_cyc == 0) begin
            total++; bad++;
            $display("FAIL done_timeout got=none want=cpu_done addr=%0h", a);
        end
    endtask

    task automatic do_check(input logic we, input logic [9:0] a, input logic [31:0] wd,
                            input int lat, input logic use_tab, input logic [31:0] tab_rd,
                            input logic tab_hit);
        logic [31:0] r_rd, e_rd, got_rd;
        logic        r_hit, e_hit;
        int          got_cyc, wr0, mb0, e_cyc;
        ref_access(we, a, wd, r_rd, r_hit);
        e_rd  = use_tab ? tab_rd  : r_rd;
        e_hit = use_tab ? tab_hit : r_hit;
        exp_mem_addr = a[9:2]; exp_mem_we = we; exp_mem_wd = wd;
        wr0 = wr_cnt; mb0 = mem_bad; req_cycles = 0;
        access(we, a, wd, lat, got_rd, got_cyc);
        e_cyc = we ? 1 + lat : (e_hit ? 1 : 2 + lat);
        check("latency", 32'(got_cyc), 32'(e_cyc));
        if (!we) check("rdata", got_rd, e_rd);
        check("hit_cnt", 32'(hit_cnt), 32'(ref_hit));
        check("miss_cnt", 32'(miss_cnt), 32'(ref_miss));
        check("array_writes", 32'(wr_cnt - wr0), (we || !e_hit) ? 32'd1 : 32'd0);
        check("mem_req_cycles", 32'(req_cycles), (!we && e_hit) ? 32'd0 : 32'(lat));
        check("mem_if_stable", 32'(mem_bad - mb0), 32'd0);
        if (we || !e_hit) begin
            check("wr_index", 32'(last_idx), 32'(a[6:2]));
            check("wr_tag", 32'(last_tag), 32'(a[9:7]));
            check("wr_valid", 32'(last_valid), 32'd1);
            check("wr_data", last_data, we ? wd : e_rd);
        end
    endtask

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rd;
        logic        exp_hit;
    } vec_t;

    initial begin
        vec_t        tab [10];
        logic [9:0]  ba [3];
        logic [31:0] be [3];
        logic [31:0] r_rd, got_rd;
        logic        r_hit;
        int          got_cyc, wr0;

        tab[0] = '{1'b1, 10'h0A8, 32'hAAAA1598, 3, 32'h0,        1'b0};
        tab[1] = '{1'b0, 10'h0A8, 32'h0,        1, 32'hAAAA1598, 1'b1};
        tab[2] = '{1'b0, 10'h2A8, 32'h0,        2, 32'h12345678, 1'b0};
        tab[3] = '{1'b0, 10'h0A8, 32'h0,        1, 32'hAAAA1598, 1'b0};
        tab[4] = '{1'b1, 10'h0A8, 32'h55550001, 2, 32'h0,        1'b1};
        tab[5] = '{1'b0, 10'h0A8, 32'h0,        1, 32'h55550001, 1'b1};
        tab[6] = '{1'b1, 10'h004, 32'h0BADF00D, 1, 32'h0,        1'b0};
        tab[7] = '{1'b1, 10'h008, 32'h600DCAFE, 4, 32'h0,        1'b0};
        tab[8] = '{1'b0, 10'h004, 32'h0,        1, 32'h0BADF00D, 1'b1};
        tab[9] = '{1'b0, 10'h00C, 32'h0,        1, 32'hC0DE0003, 1'b0};

        for (int i = 0; i < 32; i++) begin
            c_valid[i] = 1'b0; c_tag[i] = 3'd0; c_data[i] = 32'h0;
            ref_valid[i] = 1'b0; ref_tag[i] = 3'd0; ref_data[i] = 32'h0;
        end
        for (int i = 0; i < 256; i++) begin
            mem_store[i] = 32'hC0DE0000 | 32'(i);
            ref_mem[i]   = 32'hC0DE0000 | 32'(i);
        end
        mem_store[8'hAA] = 32'h12345678;
        ref_mem[8'hAA]   = 32'h12345678;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; stat_clr = 0;
        mem_ack = 0; mem_rdata = 0;

        // Reset pulse
        RST = 1'b1;
        #2 RST = 1'b0;
        #5 RST = 1'b1;
        #1;
        check("rst_cpu_done", 32'(cpu_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_cache_WE", 32'(cache_WE), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(negedge CLK);

        // Directed table
        for (int i = 0; i < 10; i++)
            do_check(tab[i].we, tab[i].addr, tab[i].wdata, tab[i].lat, 1'b1,
                     tab[i].exp_rd, tab[i].exp_hit);

        // Back-to-back hits with cpu_req held high
        ba[0] = 10'h0A8; ba[1] = 10'h004; ba[2] = 10'h008;
        for (int i = 0; i < 3; i++) ref_access(1'b0, ba[i], 32'h0, be[i], r_hit);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ba[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("b2b_gap", 32'(cpu_done), 32'd0);
            if (i < 2) cpu_addr = ba[i+1];
            else       cpu_req  = 1'b0;
            @(negedge CLK);
            check("b2b_done", 32'(cpu_done), 32'd1);
            check("b2b_rdata", cpu_rdata, be[i]);
        end
        check("b2b_hit_cnt", 32'(hit_cnt), 32'(ref_hit));

        // Random traffic over a few conflicting sets
        for (int n = 0; n < 40; n++) begin
            logic [9:0] ra;
            ra = {3'($urandom), 3'b000, 2'($urandom), 2'($urandom)};
            do_check(1'($urandom), ra, $urandom, int'($urandom_range(1, 4)), 1'b0, 32'h0, 1'b0);
        end

        // Reset while waiting on memory for a load miss
        wr0 = wr_cnt;
        mem_lat = 50;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FC;
        @(negedge CLK);
        cpu_req = 1'b0;
        @(negedge CLK);
        check("mid_rst_req_before", 32'(mem_req), 32'd1);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cpu_rdata", cpu_rdata, 32'd0);
        check("mid_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        ref_hit = 0; ref_miss = 0;
        begin
            int dn = 0;
            repeat (5) begin
                @(negedge CLK);
                if (cpu_done) dn++;
            end
            check("mid_rst_no_done", 32'(dn), 32'd0);
        end
        check("mid_rst_no_fill", 32'(wr_cnt - wr0), 32'd0);
        do_check(1'b0, 10'h3FC, 32'h0, 2, 1'b0, 32'h0, 1'b0);

        // Saturate the hit counter, then clear in the same cycle as a hit
        do_check(1'b1, 10'h3F0, 32'hFEEDBEEF, 1, 1'b0, 32'h0, 1'b0);
        for (int n = 0; n < SAT + 5; n++)
            do_check(1'b0, 10'h3F0, 32'h0, 1, 1'b0, 32'h0, 1'b0);
        check("hit_saturated", 32'(hit_cnt), 32'hFF);
        ref_access(1'b0, 10'h3F0, 32'h0, r_rd, r_hit);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3F0;
        @(negedge CLK);
        cpu_req = 1'b0; stat_clr = 1'b1;
        @(negedge CLK);
        stat_clr = 1'b0;
        ref_hit = 0; ref_miss = 0;
        check("clr_done", 32'(cpu_done), 32'd1);
        check("clr_rdata", cpu_rdata, r_rd);
        check("clr_hit_cnt", 32'(hit_cnt), 32'd0);
        check("clr_miss_cnt", 32'(miss_cnt), 32'd0);
        do_check(1'b0, 10'h3F0, 32'h0, 1, 1'b0, 32'h0, 1'b0);

        got_rd = 32'h0; got_cyc = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the direct-mapped, 32-entry, one-word-per-block `cache_memory` array. It sits between the RISC-V core's data port and a multi-cycle main memory. Each core request is split into tag, index and offset, the array is probed, and the controller services read hits, read misses and write-through/write-allocate stores. It also keeps saturating hit and miss counters.

## Interface
Parameters:
- `CNT_W`, 16: width of the hit and miss counters.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  request strobe; sampled only in IDLE.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  10  byte address: tag `[9:7]`, index `[6:2]`, offset `[1:0]`.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data; valid while `cpu_done` = 1.
- `cpu_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high when state ≠ IDLE.
- `stat_clr`  in  1  synchronous clear of both counters.
- `hit_cnt`, `miss_cnt`  out  CNT_W  saturating access counters.
- `cache_data_in`  out  32  array write data.
- `cache_block_num`  out  5  array index.
- `cache_byte_offset`  out  2  array offset.
- `cache_in_tag`  out  3  array tag.
- `cache_in_valid`  out  1  array valid bit to write.
- `cache_WE`  out  1  array write enable.
- `cache_data_out`  in  32  array read data (combinational on index).
- `cache_out_tag`  in  3  stored tag.
- `cache_out_valid`  in  1  stored valid bit.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  8  word address = `addr[9:2]`.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle memory completion.

## Operation
- States: IDLE, COMPARE, MEM_RD, FILL, MEM_WR.
- **IDLE**
  - If `cpu_req` = 1: latch `cpu_we`, `cpu_addr` and `cpu_wdata`, then go to COMPARE.
  - `cpu_req` while busy is ignored. The core may drop `cpu_req` after acceptance.
- **Cache index/tag/offset outputs**
  - `cache_block_num`, `cache_in_tag` and `cache_byte_offset` are driven continuously from the latched address.
  - `cache_in_valid` = 1 whenever `cache_WE` = 1.
- **Hit rule**: hit = `cache_out_valid` && (`cache_out_tag` == latched tag). It is evaluated in COMPARE only.
- **COMPARE**
  - Load hit: register `cpu_rdata` ← `cache_data_out`, pulse `cpu_done`, return to IDLE, increment `hit_cnt`.
  - Load miss: go to MEM_RD, increment `miss_cnt`.
  - Store (hit or miss): drive `cache_WE` = 1 with `cache_data_in` = latched wdata (write-allocate), then go to MEM_WR. Count the hit or miss by the hit rule, using the pre-write contents.
- **MEM_RD**
  - Drive `mem_req` = 1, `mem_we` = 0.
  - On `mem_ack`: capture `mem_rdata` into the fill register, then go to FILL.
- **FILL**
  - Drive `cache_WE` = 1 with `cache_data_in` = fill register.
  - Register `cpu_rdata` ← fill register, pulse `cpu_done`, go to IDLE.
- **MEM_WR**
  - Drive `mem_req` = 1, `mem_we` = 1, `mem_wdata` = latched wdata.
  - On `mem_ack`: pulse `cpu_done`, go to IDLE. `cpu_rdata` is unchanged.
- **Defaults**: `cache_WE` = 0 outside COMPARE-store and FILL. `mem_req` = 0 outside MEM_RD and MEM_WR.
- **mem_ack handling**: ignored in IDLE, COMPARE and FILL. Memory latency is unbounded; there is no timeout.
- **Counters**
  - Each saturates at all-ones.
  - `stat_clr` clears both and wins over a same-cycle increment.
- The offset is passed through to the array only; all accesses are full-word.

## Timing
- **Reset values**: state IDLE; `cpu_done`, `busy`, `mem_req`, `mem_we`, `cache_WE` = 0; `cpu_rdata`, `mem_addr`, `mem_wdata`, `hit_cnt`, `miss_cnt` = 0.
- Reset asserted mid-operation aborts the access immediately:
  - `mem_req` drops asynchronously and no `cpu_done` is issued.
  - Array contents are not touched by the controller.
- **Request accepted at edge N** (state becomes COMPARE at N):
  - Load hit: `cpu_done` is high in the cycle after edge N+1. Latency = 2 cycles.
  - Load miss with `mem_ack` in cycle k: array fill at the edge ending FILL; `cpu_done` is high in the cycle after the FILL edge.
  - Store: array written at edge N+1; `cpu_done` is high in the cycle after the `mem_ack` edge.
- While `cpu_done` is high the controller is in IDLE, so a new `cpu_req` in that cycle is accepted (back-to-back, zero bubbles).
- `mem_addr`, `mem_we` and `mem_wdata` are stable for the full duration of `mem_req`.

## Test plan
- **Reset**: pulse `RST` low for 5 ns → all outputs 0, `busy` = 0, counters 0.
- **Store miss, then load hit at the same address**:
  - Store 0xAAAA1598 to 0x0A8, memory ack after 3 cycles → `cache_WE` pulse with index 10, tag 3'b001; `mem_addr` 0x2A; `miss_cnt` = 1.
  - Then load 0x0A8 → `cpu_rdata` = 0xAAAA1598 2 cycles after acceptance; `hit_cnt` = 1; no `mem_req`.
- **Conflict miss**:
  - Load 0x2A8 (tag 3'b101, index 10), memory returns 0x12345678 → miss, fill, `cpu_rdata` = 0x12345678.
  - Reload 0x0A8 → miss again.
- **Back-to-back hits**: `cpu_req` held high over three hit loads → `cpu_done` high every other cycle with the correct data each time.
- **Reset during MEM_RD**: drop `RST` two cycles into the memory wait → `mem_req` falls immediately, no `cpu_done`; next access starts normally from IDLE.
- **Counter saturation and clear**:
  - Force `hit_cnt` to 0xFFFF with hits → it stays 0xFFFF.
  - `stat_clr` in the same cycle as a hit → both counters read 0.
